// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer driving one shared WIDTH-bit adder slice.
// Walks slices LSB first and injects inter-slice carries with an extra +1 pass.
module mp_add_seq #(
  parameter int WIDTH  = 8,
  parameter int NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [WIDTH*NSLICE-1:0]   a,
  input  logic [WIDTH*NSLICE-1:0]   b,
  output logic [WIDTH-1:0]          add_x,
  output logic [WIDTH-1:0]          add_h,
  input  logic [WIDTH-1:0]          add_sum,
  input  logic                      add_cout,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*NSLICE-1:0]   result,
  output logic                      cout,
  output logic                      ovf
);

  localparam int N  = WIDTH * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, SUM, INC, DONE} state_t;

  state_t          state, state_d;
  logic [N-1:0]    a_r, b_r, acc, acc_d;
  logic [IW-1:0]   idx, idx_d;
  logic            carry, carry_d;
  logic            c1, c1_d;
  logic            fin;

  assign busy = (state == SUM) || (state == INC);
  assign done = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    add_x   = '0;
    add_h   = '0;
    acc_d   = acc;
    idx_d   = idx;
    carry_d = carry;
    c1_d    = c1;
    fin     = 1'b0;
    case (state)
      IDLE: if (start) state_d = SUM;
      SUM: begin
        add_x = a_r[idx*WIDTH +: WIDTH];
        add_h = b_r[idx*WIDTH +: WIDTH];
        acc_d[idx*WIDTH +: WIDTH] = add_sum;
        c1_d = add_cout;
        if (carry) begin
          state_d = INC;
        end else begin
          carry_d = add_cout;
          if (idx == LAST) begin
            state_d = DONE;
            fin     = 1'b1;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      INC: begin
        // Second pass adds the pending carry-in to the partial written by SUM.
        add_x = acc[idx*WIDTH +: WIDTH];
        add_h = WIDTH'(1);
        acc_d[idx*WIDTH +: WIDTH] = add_sum;
        carry_d = c1 | add_cout;
        if (idx == LAST) begin
          state_d = DONE;
          fin     = 1'b1;
        end else begin
          idx_d   = idx + IW'(1);
          state_d = SUM;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: operand and partial registers are reset too, so a reset mid-operation leaves nothing stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      c1     <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      acc   <= '0;
      idx   <= '0;
      carry <= sub;
      c1    <= 1'b0;
    end else begin
      acc   <= acc_d;
      idx   <= idx_d;
      carry <= carry_d;
      c1    <= c1_d;
      // Visible results change only as the operation completes, so they are valid with done.
      if (fin) begin
        result <= acc_d;
        cout   <= carry_d;
        ovf    <= (a_r[N-1] == b_r[N-1]) & (acc_d[N-1] != a_r[N-1]);
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed corner cases plus random operands,
// checked every cycle against a plain-arithmetic model of the whole operation.
module tb_mp_add_seq;

  localparam int W  = 8;
  localparam int NS = 4;
  localparam int N  = W * NS;

  typedef struct {
    logic [N-1:0] res;
    logic         cout;
    logic         ovf;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [W-1:0] add_x, add_h, add_sum;
  logic         add_cout;
  logic         busy, done, cout, ovf;
  logic [N-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Shared adder slice: plain W-bit add with carry out, no carry in.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_h};

  mp_add_seq #(.WIDTH(W), .NSLICE(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .add_x(add_x), .add_h(add_h), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-operation model: one wide add, plus latency from the carry into each slice.
  function automatic exp_t model(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic s);
    exp_t e;
    logic [N-1:0] be;
    logic [N:0]   full, part, mask;
    be     = s ? ~xb : xb;
    full   = {1'b0, xa} + {1'b0, be} + (N+1)'(s);
    e.res  = full[N-1:0];
    e.cout = full[N];
    e.ovf  = (xa[N-1] == be[N-1]) && (e.res[N-1] != xa[N-1]);
    e.lat  = NS;
    for (int i = 0; i < NS; i++) begin
      mask = ((N+1)'(1) << (W*i)) - (N+1)'(1);
      part = ({1'b0, xa} & mask) + ({1'b0, be} & mask) + (N+1)'(s);
      if (part[W*i]) e.lat++;
    end
    return e;
  endfunction

  // Acceptance capture: an op starts at the edge that sees start while the DUT sat idle.
  int   acc_seq = 0;
  exp_t acc_exp;
  logic was_idle = 1'b1;

  always @(posedge clk) begin
    if (!rst && was_idle && start) begin
      acc_exp = model(a, b, sub);
      acc_seq++;
    end
  end

  // Single compare process, sampled on the falling edge.
  int           seen_seq = 0;
  logic         pending = 1'b0;
  exp_t         cur;
  int           busy_cnt = 0;
  logic         prev_done = 1'b0;
  logic [N-1:0] last_res = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout_ovf", {cout, ovf}, 0);
      check("rst_adder_in", {add_x, add_h}, 0);
      pending   = 1'b0;
      seen_seq  = acc_seq;
      last_res  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      prev_done = 1'b0;
      was_idle  = 1'b1;
    end else begin
      if (acc_seq != seen_seq) begin
        seen_seq = acc_seq;
        cur      = acc_exp;
        pending  = 1'b1;
        busy_cnt = 0;
        check("busy_after_accept", busy, 1);
      end
      if (busy) begin
        busy_cnt++;
        if (pending && busy_cnt > 2*NS) begin
          check("latency_bound", busy_cnt, 2*NS);
          pending = 1'b0;
        end
      end
      if (done) begin
        check("single_done_pulse", prev_done, 0);
        check("done_expected", pending, 1);
        if (pending) begin
          check("result", result, cur.res);
          check("cout", cout, cur.cout);
          check("ovf", ovf, cur.ovf);
          check("busy_cycles", busy_cnt, cur.lat);
          last_res  = cur.res;
          last_cout = cur.cout;
          last_ovf  = cur.ovf;
          pending   = 1'b0;
        end
      end
      if (!busy && !done) begin
        check("idle_adder_in", {add_x, add_h}, 0);
        check("idle_hold", {result, cout, ovf}, {last_res, last_cout, last_ovf});
      end
      prev_done = done;
      was_idle  = !busy && !done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, wait for done, and optionally pin it to literals.
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic s,
                        input logic pin, input logic [N-1:0] er, input logic ec,
                        input logic eo, input int el, input logic pulse);
    int lat = 0;
    logic got = 1'b0;
    tick();
    a = xa; b = xb; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) lat++;
      start = pulse && (lat == 2);
      if (done) begin
        got = 1'b1;
        if (pin) begin
          check("pin_result", result, er);
          check("pin_cout", cout, ec);
          check("pin_ovf", ovf, eo);
          check("pin_busy_cycles", lat, el);
        end
      end else begin
        tick();
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [N-1:0] ra, rb;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 5, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 7, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 5, 1'b0);
    run_op(32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 8, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 7, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 5, 1'b0);
    // start pulsed during SUM must be ignored.
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0, 4, 1'b1);
    repeat (4) tick();

    // start held high: back-to-back operations with one idle cycle between.
    tick();
    a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 60 && dones < 3; i++) begin
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    check("held_start_dones", dones, 3);
    repeat (3) tick();

    // Reset while in INC (third busy cycle of 0xFF + 1).
    tick();
    a = 32'h000000FF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_adder_in", {add_x, add_h}, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 5, 1'b0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFFFFFF;
        1: ra = 32'(($urandom_range(0, 1) << 31) | $urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'(1);
        1: rb = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0, 0,
             1'($urandom_range(0, 1)));
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
